i2c_slave_responder: RTL

- Target-side (slave) end of the team's I2C link; the responder to the master whose SCL is generated by the SSU clock path.
- Oversamples SCL/SDA on the system clock Mclk and detects START, repeated START and STOP.
- Matches a 7-bit address, ACKs, then receives write bytes or shifts out read bytes through an open-drain SDA pull-down.
- Sits between the pad (SCL/SDA inputs, SDA output-enable) and a simple byte-level user handshake.

---
 rtl/i2c_pkg.sv | 19 +
 rtl/i2c_bus_sync.sv | 45 ++++
 rtl/i2c_slave_responder.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target-side responder and bus helpers.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD_DATA,
        ST_RD_ACK,
        ST_WAIT_STOP
    } i2c_state_e;

    localparam logic I2C_ACK   = 1'b0;
    localparam logic I2C_NACK  = 1'b1;
    localparam int   BYTE_BITS = 8;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizers with edge strobes and START/STOP detection on the system clock.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic Mclk,
    input  logic reset_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic                   scl_d, sda_d;
    logic                   scl;
    logic                   sda_rise, sda_fall;

    // Reset to 1 so an idle bus produces no edges after reset release.
    always_ff @(posedge Mclk or negedge reset_n) begin
        if (!reset_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_d    <= scl_sync[SYNC_STAGES-1];
            sda_d    <= sda_sync[SYNC_STAGES-1];
        end
    end

    assign scl      = scl_sync[SYNC_STAGES-1];
    assign sda      = sda_sync[SYNC_STAGES-1];
    assign scl_rise =  scl & ~scl_d;
    assign scl_fall = ~scl &  scl_d;
    assign sda_rise =  sda & ~sda_d;
    assign sda_fall = ~sda &  sda_d;
    assign start    = sda_fall & scl;
    assign stop     = sda_rise & scl;

endmodule

// File: rtl/i2c_slave_responder.sv
// I2C target: address match, write-byte receive and read-byte transmit via open-drain SDA.
module i2c_slave_responder
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = 7'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       Mclk,
    input  logic       reset_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_next,
    output logic       busy,
    output logic       start_det,
    output logic       stop_det
);

    localparam logic [3:0] LAST_BIT = 4'(BYTE_BITS - 1);
    localparam logic [3:0] FULL_CNT = 4'(BYTE_BITS);

    logic sda, scl_rise, scl_fall, start, stop;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .Mclk     (Mclk),
        .reset_n  (reset_n),
        .scl_in   (scl_in),
        .sda_in   (sda_in),
        .sda      (sda),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop)
    );

    i2c_state_e             state;
    logic [3:0]             bit_cnt;
    logic [BYTE_BITS-2:0]   shreg;
    logic [BYTE_BITS-2:0]   tx_shift;
    logic                   rw;
    logic                   addr_hit;
    logic                   rx_ack;

    always_ff @(posedge Mclk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            tx_shift  <= '0;
            rw        <= 1'b0;
            addr_hit  <= 1'b0;
            rx_ack    <= 1'b0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            tx_next   <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            tx_next   <= 1'b0;
            start_det <= start;
            stop_det  <= stop;
            if (start) begin
                state    <= ST_ADDR;
                bit_cnt  <= '0;
                sda_oe   <= 1'b0;
                addr_hit <= 1'b0;
            end else if (stop) begin
                state  <= ST_IDLE;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else begin
                case (state)
                    ST_ADDR: begin
                        if (scl_rise && bit_cnt != FULL_CNT) begin
                            shreg   <= {shreg[BYTE_BITS-3:0], sda};
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == LAST_BIT) begin
                                rw <= sda;
                                if (shreg == SLAVE_ADDR) begin
                                    addr_hit <= 1'b1;
                                end else begin
                                    busy  <= 1'b0;
                                    state <= ST_WAIT_STOP;
                                end
                            end
                        end else if (scl_fall && bit_cnt == FULL_CNT && addr_hit) begin
                            sda_oe <= 1'b1;
                            busy   <= 1'b1;
                            state  <= ST_ADDR_ACK;
                        end
                    end
                    ST_ADDR_ACK: begin
                        if (scl_fall) begin
                            bit_cnt <= '0;
                            if (!rw) begin
                                sda_oe <= 1'b0;
                                state  <= ST_WR_DATA;
                            end else begin
                                tx_next  <= 1'b1;
                                tx_shift <= tx_data[6:0];
                                sda_oe   <= ~tx_data[7];
                                state    <= ST_RD_DATA;
                            end
                        end
                    end
                    ST_WR_DATA: begin
                        if (scl_rise && bit_cnt != FULL_CNT) begin
                            shreg   <= {shreg[BYTE_BITS-3:0], sda};
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == LAST_BIT) begin
                                rx_data  <= {shreg, sda};
                                rx_valid <= 1'b1;
                                rx_ack   <= rx_ready;
                            end
                        end else if (scl_fall && bit_cnt == FULL_CNT) begin
                            sda_oe <= rx_ack;
                            state  <= ST_WR_ACK;
                        end
                    end
                    ST_WR_ACK: begin
                        if (scl_fall) begin
                            sda_oe <= 1'b0;
                            if (rx_ack) begin
                                bit_cnt <= '0;
                                state   <= ST_WR_DATA;
                            end else begin
                                state <= ST_WAIT_STOP;
                            end
                        end
                    end
                    ST_RD_DATA: begin
                        // Bit 7 went out on entry; each fall moves to the next bit,
                        // the fall after bit 0 hands SDA back for the master's ACK.
                        if (scl_fall) begin
                            if (bit_cnt == LAST_BIT) begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= FULL_CNT;
                                state   <= ST_RD_ACK;
                            end else begin
                                sda_oe   <= ~tx_shift[BYTE_BITS-2];
                                tx_shift <= {tx_shift[BYTE_BITS-3:0], 1'b0};
                                bit_cnt  <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    ST_RD_ACK: begin
                        if (scl_rise) begin
                            if (sda == I2C_NACK) begin
                                sda_oe <= 1'b0;
                                busy   <= 1'b0;
                                state  <= ST_WAIT_STOP;
                            end
                        end else if (scl_fall) begin
                            tx_next  <= 1'b1;
                            tx_shift <= tx_data[6:0];
                            sda_oe   <= ~tx_data[7];
                            bit_cnt  <= '0;
                            state    <= ST_RD_DATA;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
